// File: rtl/mem_addr_arbiter.sv
// rtl/mem_addr_arbiter.sv - round-robin owner arbiter for the shared 8:1 memory address mux
module mem_addr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               mem_en,
  output logic               busy,
  output logic               preempt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Last value of the hold counter; with preemption disabled the counter never moves.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_mem_en;
  logic               r_busy;
  logic               r_preempt;

  logic               w_found;
  logic [SEL_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_rel_done;
  logic               w_rel_drop;
  logic               w_rel_hold;
  logic               w_release;

  // Rotating priority scan: first requester at or after r_ptr, wrapping past the top index.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[r_ptr + SEL_W'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + SEL_W'(i);
      end
    end
  end

  // Release conditions for the current owner; only the owner's req/done bits matter here.
  always_comb begin
    w_owner_oh = NUM_REQ'(1) << r_owner;
    w_rel_done = done[r_owner];
    w_rel_drop = !req[r_owner];
    w_rel_hold = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) && ((req & ~w_owner_oh) != '0);
    w_release  = w_rel_done || w_rel_drop || w_rel_hold;
  end

  // Arbitration FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_grant    <= '0;
      r_sel      <= '0;
      r_mem_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_TURN: begin
          r_preempt <= 1'b0;
          if (w_found) begin
            r_owner    <= w_winner;
            r_sel      <= w_winner;
            r_grant    <= NUM_REQ'(1) << w_winner;
            r_mem_en   <= 1'b1;
            r_hold_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_GRANT;
          end else begin
            r_grant  <= '0;
            r_mem_en <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_grant   <= '0;
            r_mem_en  <= 1'b0;
            r_ptr     <= r_owner + SEL_W'(1);
            r_busy    <= 1'b1;
            r_state   <= ST_TURN;
            // A revoke only counts as preemption when the owner was not finishing anyway.
            r_preempt <= w_rel_hold && !w_rel_done && !w_rel_drop;
          end else begin
            r_preempt <= 1'b0;
            if (r_hold_cnt != HOLD_LAST) begin
              r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_grant   <= '0;
          r_mem_en  <= 1'b0;
          r_busy    <= 1'b0;
          r_preempt <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign mem_en  = r_mem_en;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// tb/tb_mem_addr_arbiter.sv - directed scoreboard bench for mem_addr_arbiter
module tb_mem_addr_arbiter;

  logic       clk;
  logic       nrst;
  logic [7:0] req;
  logic [7:0] done;

  // Instance 0: default MAX_HOLD=64, 1: MAX_HOLD=4, 2: MAX_HOLD=2
  logic [7:0] grant_o   [3];
  logic [2:0] sel_o     [3];
  logic       mem_en_o  [3];
  logic       busy_o    [3];
  logic       preempt_o [3];

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       m;
    logic       b;
    logic       p;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    inst_q[$];

  int n_cmp;
  int n_err;

  mem_addr_arbiter u_dut (
    .clk(clk), .nrst(nrst), .req(req), .done(done),
    .grant(grant_o[0]), .sel(sel_o[0]), .mem_en(mem_en_o[0]),
    .busy(busy_o[0]), .preempt(preempt_o[0])
  );

  mem_addr_arbiter #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .nrst(nrst), .req(req), .done(done),
    .grant(grant_o[1]), .sel(sel_o[1]), .mem_en(mem_en_o[1]),
    .busy(busy_o[1]), .preempt(preempt_o[1])
  );

  mem_addr_arbiter #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .nrst(nrst), .req(req), .done(done),
    .grant(grant_o[2]), .sel(sel_o[2]), .mem_en(mem_en_o[2]),
    .busy(busy_o[2]), .preempt(preempt_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observe(input int inst);
    exp_t o;
    o.g = grant_o[inst];
    o.s = sel_o[inst];
    o.m = mem_en_o[inst];
    o.b = busy_o[inst];
    o.p = preempt_o[inst];
    return o;
  endfunction

  task automatic push(input string tag, input int inst, input logic [7:0] g, input logic [2:0] s,
                      input logic m, input logic b, input logic p);
    exp_t e;
    e.g = g; e.s = s; e.m = m; e.b = b; e.p = p;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    inst_q.push_back(inst);
  endtask

  task automatic check_pop();
    exp_t  e;
    exp_t  o;
    string t;
    int    inst;
    e    = sb_q.pop_front();
    t    = tag_q.pop_front();
    inst = inst_q.pop_front();
    o    = observe(inst);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed grant=%h sel=%0d mem_en=%b busy=%b preempt=%b expected grant=%h sel=%0d mem_en=%b busy=%b preempt=%b",
             t, o.g, o.s, o.m, o.b, o.p, e.g, e.s, e.m, e.b, e.p);
    end
  endtask

  // Expectation for the state after the next rising edge.
  task automatic step(input string tag, input int inst, input logic [7:0] g, input logic [2:0] s,
                      input logic m, input logic b, input logic p);
    push(tag, inst, g, s, m, b, p);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    req  = '0;
    done = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst  = 1'b0;
    req   = '0;
    done  = '0;
    do_reset();

    // Reset state on every instance
    for (int k = 0; k < 3; k++) begin
      push("reset", k, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      check_pop();
    end

    // Single requester, done release, turnaround then idle
    req = 8'h04;
    step("single_grant", 0, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    done = 8'h04;
    step("single_turn", 0, 8'h00, 3'd2, 1'b0, 1'b1, 1'b0);
    done = 8'h00;
    req  = 8'h00;
    step("single_idle", 0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);

    // All eight requesting: strict rotation with one gap cycle, wrapping 7 -> 0
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      logic [2:0] ix;
      ix = 3'(k % 8);
      oh = 8'h01 << ix;
      step("rr_grant", 0, oh, ix, 1'b1, 1'b1, 1'b0);
      step("rr_hold1", 0, oh, ix, 1'b1, 1'b1, 1'b0);
      step("rr_hold2", 0, oh, ix, 1'b1, 1'b1, 1'b0);
      done = oh;
      step("rr_gap", 0, 8'h00, ix, 1'b0, 1'b1, 1'b0);
      done = 8'h00;
    end

    // MAX_HOLD=4 preemption of owner 5 by requester 1
    do_reset();
    req = 8'h20;
    step("hold4_c0", 1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    step("hold4_c1", 1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    req = 8'h22;
    step("hold4_c2", 1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    step("hold4_c3", 1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    step("hold4_preempt", 1, 8'h00, 3'd5, 1'b0, 1'b1, 1'b1);
    step("hold4_next", 1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);

    // MAX_HOLD=4 with no competitor: owner keeps the bus indefinitely
    do_reset();
    req = 8'h20;
    for (int k = 0; k < 110; k++) begin
      step("hold4_persist", 1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    end

    // Foreign done ignored; owner dropping req releases without preempt, ptr moves to 4
    do_reset();
    req = 8'h08;
    step("own3_grant", 0, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    done = 8'h40;
    step("own3_foreign_done", 0, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    done = 8'h00;
    req  = 8'h00;
    step("own3_drop", 0, 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
    req = 8'h29;
    step("own3_ptr4", 0, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    req = 8'h00;

    // Async reset in the middle of owner 7's grant
    do_reset();
    req = 8'h80;
    step("own7_grant", 0, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
    step("own7_hold1", 0, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
    step("own7_hold2", 0, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    push("async_reset", 0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check_pop();
    @(negedge clk);
    nrst = 1'b1;
    req  = 8'h81;
    step("after_reset_ptr0", 0, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

    // MAX_HOLD=2: done coincides with preemption -> no preempt; then a real preemption
    do_reset();
    req = 8'h03;
    step("hold2_grant0", 2, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
    step("hold2_hold", 2, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
    done = 8'h01;
    step("hold2_done_wins", 2, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    done = 8'h00;
    step("hold2_grant1", 2, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);
    step("hold2_hold1", 2, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);
    step("hold2_preempt", 2, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1);
    step("hold2_regrant0", 2, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
    req = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_addr_arbiter.md
Name: mem_addr_arbiter

Overview:
- Round-robin arbiter that shares the single memory address path among the eight processing units feeding the 8:1 address mux.
- Unit indices: 0 learnCost, 1 amISink, 2 fixSinkList, 3 neighborSinkInOtherCluster, 4 findMyBest, 5 betterNeighborsInMyCluster, 6 winnerPolicy, 7 selectMyAction.
- Grants exclusive bus ownership to one unit, drives the mux select and the memory enable, and enforces a bounded hold time so no unit starves the others.

Parameters:
- NUM_REQ, 8, number of requesters; fixed at 8 to match the mux.
- SEL_W, 3, select width.
- MAX_HOLD, 64, maximum cycles in GRANT while other requests are pending; 0 disables preemption.
- CNT_W, 7, hold counter width; must hold MAX_HOLD-1.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- req  input  8  request per unit; held high for the whole access burst.
- done  input  8  one-cycle end-of-burst pulse per unit.
- grant  output  8  one-hot ownership, registered.
- sel  output  3  mux select = owner index, registered.
- mem_en  output  1  memory access enable; high exactly while grant != 0.
- busy  output  1  high when state != IDLE.
- preempt  output  1  one-cycle pulse when ownership is revoked by MAX_HOLD.

Behaviour:
- Reset values (async assert, sync deassert use): state=IDLE, grant=0, sel=0, mem_en=0, busy=0, preempt=0, ptr=0, owner=0, hold_cnt=0.
- Reset asserted mid-grant: all outputs drop immediately, without waiting for a clock edge.

State IDLE:
- At a rising edge with req != 0: pick the first set bit scanning ptr, ptr+1, …, wrapping mod 8.
- On that edge: load owner and sel with the winner index, grant=onehot(owner), mem_en=1, hold_cnt=0, go to GRANT.
- Latency: request to grant is 1 cycle.

State GRANT:
- Each edge, evaluate the release conditions in this priority order:
  - (a) done[owner]=1;
  - (b) req[owner]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and (req & ~onehot(owner)) != 0.
- Any of (a)-(c) true: grant=0, mem_en=0, ptr=(owner+1) mod 8, go to TURN.
- preempt=1 for that one cycle only if (c) alone caused the release. If (a) or (b) is also true, preempt stays 0.
- Otherwise stay in GRANT. hold_cnt increments and saturates at MAX_HOLD-1.
- With no other requester, the owner keeps the grant indefinitely. Preemption fires on the first edge another request is seen once hold_cnt is saturated.
- done[i] and req[i] for i != owner are ignored while in GRANT. A non-owner done pulse is discarded and not remembered.

State TURN (one-cycle bus turnaround):
- grant=0, mem_en=0, preempt cleared.
- Arbitration is identical to IDLE using the updated ptr. If req != 0, go to GRANT with a new owner; else go to IDLE.
- Minimum gap between two grants is exactly 1 idle cycle.

General rules:
- sel holds its last value while no grant is active. The mux output is don't-care then because mem_en=0.
- Wrap-around: ptr goes 7→0, and the scan from ptr wraps past index 7 to 0.
- Simultaneous requests: round-robin order from ptr. With all 8 requesting, the grant order is a strict rotation.
- A requester re-raising req in the same TURN cycle it was just released competes normally. It wins only if no higher-rotation unit is requesting.

Test Plan:
- Reset, then req=8'h04 at edge 0 -> grant=8'h04, sel=2, mem_en=1 after edge 0. done[2] pulse -> grant=0 for 1 cycle, then busy=0.
- req=8'hFF held, each owner pulses done after 3 cycles -> grant order 0,1,…,7,0. Exactly one zero-grant cycle between owners.
- MAX_HOLD=4, req[5] held and never done, req[1] rises at cycle 2 -> grant[5] for 4 cycles, then preempt=1 pulse, turnaround, grant=8'h02. With req[1] absent, grant[5] persists more than 100 cycles.
- Owner 3 active, done[6] pulsed -> no change. Owner 3 drops req -> release, preempt stays 0, ptr=4.
- nrst pulsed low mid-grant (owner 7, hold_cnt=2) -> outputs 0 immediately. After release with req=8'h81 -> grant=8'h01 (ptr reset to 0).
- MAX_HOLD=2, owner asserts done on the same edge the preemption condition is met -> release with preempt=0.
